// File: rtl/safe_lock_pkg.sv
// Shared types and width helpers for the safe lock controller.
// Optional code change support is enabled by SAFE_LOCK_CODE_CHANGE_EN.
package safe_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    ERROR,
    LOCKOUT,
    PROG
  } state_t;

  localparam int KEY_W_D       = 4;
  localparam int CODE_LEN_D    = 4;
  localparam int MAX_TRIES_D   = 3;
  localparam int LOCK_CYCLES_D = 10;
  localparam int OPEN_CYCLES_D = 8;
  localparam int ERR_CYCLES_D  = 2;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CODE_W = KEY_W_D * CODE_LEN_D;
  localparam int CNT_W  = $clog2(CODE_LEN_D + 1);
  localparam int TMR_W  = $clog2(max3(LOCK_CYCLES_D,
                                      OPEN_CYCLES_D,
                                      ERR_CYCLES_D) + 1);

endpackage

// File: rtl/safe_lock_timer.sv
// Loadable down-counter shared by the timed lock states.
// Holds at zero; load wins over decrement.
module safe_lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/safe_lock_ctrl.sv
// Multi-digit safe lock: keypad entry, compare, open/error/lockout.
// Define SAFE_LOCK_CODE_CHANGE_EN to add set_code and the PROG state.
module safe_lock_ctrl
  import safe_lock_pkg::*;
#(
  parameter int KEY_W       = KEY_W_D,
  parameter int CODE_LEN    = CODE_LEN_D,
  parameter logic [KEY_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h0505,
  parameter int MAX_TRIES   = MAX_TRIES_D,
  parameter int LOCK_CYCLES = LOCK_CYCLES_D,
  parameter int OPEN_CYCLES = OPEN_CYCLES_D,
  parameter int ERR_CYCLES  = ERR_CYCLES_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key,
  input  logic             enter,
  input  logic             clear,
  input  logic             relock,
`ifdef SAFE_LOCK_CODE_CHANGE_EN
  input  logic             set_code,
`endif
  output logic             led_green,
  output logic             led_red,
  output logic             led_lock,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic             busy
);

  localparam int CW  = KEY_W * CODE_LEN;
  localparam int NW  = $clog2(CODE_LEN + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TW  = $clog2(max3(LOCK_CYCLES,
                                   OPEN_CYCLES,
                                   ERR_CYCLES) + 1);

  state_t state, state_d;

  logic [CW-1:0]  buf_q;
  logic [CW-1:0]  code;
  logic [NW-1:0]  cnt;
  logic [TRW-1:0] tries_d;
  logic           shift;
  logic           cnt_clr;
  logic           full;
  logic           match;
  logic           ld;
  logic [TW-1:0]  ld_val;
  logic           tmr_en;
  logic [TW-1:0]  tmr_val;
  logic           tmr_zero;
  logic           unused_tmr;

  assign full  = (cnt == NW'(CODE_LEN));
  assign match = full && (buf_q == code);

  assign tmr_en = (state == OPEN) ||
                  (state == ERROR) ||
                  (state == LOCKOUT);

  assign unused_tmr = ^tmr_val;

  safe_lock_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .en       (tmr_en),
    .value    (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef SAFE_LOCK_CODE_CHANGE_EN
  logic code_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      code <= DEFAULT_CODE;
    end else if (code_we) begin
      code <= buf_q;
    end
  end
`else
  assign code = DEFAULT_CODE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    shift   = 1'b0;
    cnt_clr = 1'b0;
    tries_d = tries_left;
    ld      = 1'b0;
    ld_val  = '0;
`ifdef SAFE_LOCK_CODE_CHANGE_EN
    code_we = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (clear) begin
          cnt_clr = 1'b1;
        end else if (enter) begin
          state_d = CHECK;
        end else if (key_valid) begin
          shift   = 1'b1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (enter) begin
          state_d = CHECK;
        end else if (key_valid) begin
          shift = 1'b1;
        end
      end
      CHECK: begin
        cnt_clr = 1'b1;
        ld      = 1'b1;
        if (match) begin
          tries_d = TRW'(MAX_TRIES);
          state_d = OPEN;
          ld_val  = TW'(OPEN_CYCLES - 1);
        end else begin
          tries_d = tries_left - TRW'(1);
          if (tries_d == '0) begin
            state_d = LOCKOUT;
            ld_val  = TW'(LOCK_CYCLES - 1);
          end else begin
            state_d = ERROR;
            ld_val  = TW'(ERR_CYCLES - 1);
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_d = IDLE;
`ifdef SAFE_LOCK_CODE_CHANGE_EN
        end else if (set_code) begin
          state_d = PROG;
`endif
        end else if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = IDLE;
          tries_d = TRW'(MAX_TRIES);
        end
      end
      PROG: begin
`ifdef SAFE_LOCK_CODE_CHANGE_EN
        if (clear) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (enter) begin
          cnt_clr = 1'b1;
          if (full) begin
            code_we = 1'b1;
            state_d = IDLE;
          end else begin
            ld      = 1'b1;
            ld_val  = TW'(ERR_CYCLES - 1);
            state_d = ERROR;
          end
        end else if (key_valid) begin
          shift = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Digits past CODE_LEN are dropped, so the first digit ends in the MSBs.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt   <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (shift && !full) begin
      buf_q <= (buf_q << KEY_W) | CW'(key);
      cnt   <= cnt + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tries_left <= TRW'(MAX_TRIES);
      led_green  <= 1'b0;
      led_red    <= 1'b0;
      led_lock   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tries_left <= tries_d;
      led_green  <= (state_d == OPEN) || (state_d == PROG);
      led_red    <= (state_d == ERROR);
      led_lock   <= (state_d == LOCKOUT);
      busy       <= (state_d == CHECK) || (state_d == OPEN) ||
                    (state_d == ERROR) || (state_d == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl (default code 0505).
// Code change scenario runs when SAFE_LOCK_CODE_CHANGE_EN is defined.
module tb_safe_lock_ctrl;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key;
  logic       enter;
  logic       clear;
  logic       relock;
`ifdef SAFE_LOCK_CODE_CHANGE_EN
  logic       set_code;
`endif
  logic       led_green;
  logic       led_red;
  logic       led_lock;
  logic [1:0] tries_left;
  logic       busy;

  int checks;
  int errors;

  safe_lock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key        (key),
    .enter      (enter),
    .clear      (clear),
    .relock     (relock),
`ifdef SAFE_LOCK_CODE_CHANGE_EN
    .set_code   (set_code),
`endif
    .led_green  (led_green),
    .led_red    (led_red),
    .led_lock   (led_lock),
    .tries_left (tries_left),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus changes and sampling happen on the falling edge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic do_enter();
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy && !led_green) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b green=%0b, need both 0",
               busy, led_green);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({led_green, led_red, led_lock, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got %b need 0000",
               {led_green, led_red, led_lock, busy});
    end
    checks++;
    if (tries_left !== 2'd3) begin
      errors++;
      $display("FAIL reset_tries: got %0d need 3", tries_left);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_open();
    int n;
    press4(16'h0505);
    do_enter();
    checks++;
    if (led_green !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL open_check_cycle: green=%0b busy=%0b need 0,1",
               led_green, busy);
    end
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1 || tries_left !== 2'd3) begin
      errors++;
      $display("FAIL open_led: green=%0b tries=%0d need 1,3",
               led_green, tries_left);
    end
    n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (led_green) n++;
      else break;
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL open_len: got %0d cycles need 8", n);
    end
    wait_idle();
  endtask

  task automatic fail_red(input logic [1:0] exp_tries);
    int n;
    press4(16'h1234);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_red !== 1'b1 || tries_left !== exp_tries) begin
      errors++;
      $display("FAIL err_led: red=%0b tries=%0d need 1,%0d",
               led_red, tries_left, exp_tries);
    end
    n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (led_red) n++;
      else break;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL err_len: got %0d cycles need 2", n);
    end
  endtask

  task automatic test_lockout();
    int n;
    fail_red(2'd2);
    fail_red(2'd1);
    press4(16'h1234);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_lock !== 1'b1 || tries_left !== 2'd0) begin
      errors++;
      $display("FAIL lock_led: lock=%0b tries=%0d need 1,0",
               led_lock, tries_left);
    end
    n = 1;
    for (int i = 0; i < 30; i++) begin
      key_valid = 1'b1;
      key = 4'h5;
      @(negedge clk);
      if (led_lock) n++;
      else break;
    end
    key_valid = 1'b0;
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL lock_len: got %0d cycles need 10", n);
    end
    checks++;
    if (tries_left !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_exit: tries=%0d busy=%0b need 3,0",
               tries_left, busy);
    end
    test_open();
  endtask

  task automatic test_entry_edges();
    press(4'h0);
    press(4'h5);
    press(4'h0);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_red !== 1'b1 || tries_left !== 2'd2) begin
      errors++;
      $display("FAIL short_entry: red=%0b tries=%0d need 1,2",
               led_red, tries_left);
    end
    wait_idle();
    press4(16'h0505);
    press(4'h7);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1 || tries_left !== 2'd3) begin
      errors++;
      $display("FAIL fifth_digit: green=%0b tries=%0d need 1,3",
               led_green, tries_left);
    end
    wait_idle();
    press(4'h0);
    press(4'h5);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    press4(16'h0505);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1) begin
      errors++;
      $display("FAIL clear_then_code: green=%0b need 1", led_green);
    end
    wait_idle();
  endtask

  task automatic test_relock();
    press4(16'h0505);
    do_enter();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1) begin
      errors++;
      $display("FAIL relock_pre: green=%0b need 1", led_green);
    end
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    checks++;
    if (led_green !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL relock: green=%0b busy=%0b need 0,0",
               led_green, busy);
    end
  endtask

  task automatic test_strobes();
    press(4'h0);
    press(4'h5);
    press(4'h0);
    key_valid = 1'b1;
    key = 4'h5;
    enter = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    enter = 1'b0;
    @(negedge clk);
    checks++;
    if (led_red !== 1'b1 || tries_left !== 2'd2) begin
      errors++;
      $display("FAIL key_enter_same: red=%0b tries=%0d need 1,2",
               led_red, tries_left);
    end
    wait_idle();
    press4(16'h0505);
    clear = 1'b1;
    enter = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enter = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || led_green !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio: busy=%0b green=%0b need 0,0",
               busy, led_green);
    end
    press4(16'h0505);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1 || tries_left !== 2'd3) begin
      errors++;
      $display("FAIL after_clear: green=%0b tries=%0d need 1,3",
               led_green, tries_left);
    end
    wait_idle();
    do_enter();
    @(negedge clk);
    checks++;
    if (led_red !== 1'b1 || tries_left !== 2'd2) begin
      errors++;
      $display("FAIL empty_enter: red=%0b tries=%0d need 1,2",
               led_red, tries_left);
    end
    wait_idle();
    relock = 1'b1;
    press4(16'h0505);
    do_enter();
    relock = 1'b0;
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1) begin
      errors++;
      $display("FAIL relock_outside: green=%0b need 1", led_green);
    end
    wait_idle();
  endtask

  task automatic test_rst_lockout();
    fail_red(2'd2);
    fail_red(2'd1);
    press4(16'h1234);
    do_enter();
    repeat (5) @(negedge clk);
    checks++;
    if (led_lock !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_lock: lock=%0b need 1", led_lock);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (led_lock !== 1'b0 || tries_left !== 2'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_lock: lock=%0b tries=%0d busy=%0b need 0,3,0",
               led_lock, tries_left, busy);
    end
    test_open();
  endtask

`ifdef SAFE_LOCK_CODE_CHANGE_EN
  task automatic test_code_change();
    press4(16'h0505);
    do_enter();
    @(negedge clk);
    set_code = 1'b1;
    @(negedge clk);
    set_code = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (led_green !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prog_hold: green=%0b busy=%0b need 1,0",
               led_green, busy);
    end
    press4(16'h9999);
    do_enter();
    checks++;
    if (led_green !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prog_exit: green=%0b busy=%0b need 0,0",
               led_green, busy);
    end
    press4(16'h9999);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_green !== 1'b1) begin
      errors++;
      $display("FAIL new_code: green=%0b need 1", led_green);
    end
    wait_idle();
    press4(16'h0505);
    do_enter();
    @(negedge clk);
    checks++;
    if (led_red !== 1'b1) begin
      errors++;
      $display("FAIL old_code: red=%0b need 1", led_red);
    end
    wait_idle();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    key_valid = 1'b0;
    key = 4'h0;
    enter = 1'b0;
    clear = 1'b0;
    relock = 1'b0;
`ifdef SAFE_LOCK_CODE_CHANGE_EN
    set_code = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_open();
    test_lockout();
    test_entry_edges();
    test_relock();
    test_strobes();
    test_rst_lockout();
`ifdef SAFE_LOCK_CODE_CHANGE_EN
    test_code_change();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/safe_lock_ctrl.md
Name: safe_lock_ctrl

Overview:
- Parametrised multi-digit safe-lock controller; next generation of the single-key password lock.
- Collects a CODE_LEN-digit entry from a keypad, compares it against a stored code on enter, and drives open/error/lockout indicators.
- Locks out for a fixed number of cycles after MAX_TRIES consecutive failures.
- Sits between the keypad debouncer/encoder and the LED/solenoid drivers; fully synchronous to clk.

Parameters:
- KEY_W, 4, bits per keypad digit.
- CODE_LEN, 4, digits per code (>=1).
- DEFAULT_CODE, 16'h0505, code loaded at reset; width KEY_W*CODE_LEN, digit 0 in MSBs.
- MAX_TRIES, 3, consecutive failures that trigger lockout (>=1).
- LOCK_CYCLES, 10, lockout duration in clk cycles (>=1).
- OPEN_CYCLES, 8, cycles led_green stays high after a match (>=1).
- ERR_CYCLES, 2, cycles led_red stays high after a mismatch (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- key_valid  input  1  one-cycle strobe; key holds a new digit.
- key  input  KEY_W  digit value, sampled when key_valid=1.
- enter  input  1  one-cycle strobe; submit the current entry.
- clear  input  1  one-cycle strobe; discard the partial entry.
- relock  input  1  force OPEN back to IDLE early.
- led_green  output  1  high in OPEN.
- led_red  output  1  high in ERROR.
- led_lock  output  1  high in LOCKOUT.
- tries_left  output  $clog2(MAX_TRIES+1)  remaining attempts before lockout.
- busy  output  1  high in CHECK, OPEN, ERROR and LOCKOUT; keypad input is ignored.

Behaviour:
- Reset values:
  - state=IDLE; all LEDs=0; busy=0.
  - tries_left=MAX_TRIES; digit count=0; stored code=DEFAULT_CODE.
- States and transitions:
  - IDLE: first key_valid stores the digit, count=1, then ENTRY.
  - ENTRY: each key_valid shifts the digit in; count increments and saturates at CODE_LEN; digits beyond CODE_LEN are dropped. clear sets count=0 and goes to IDLE. enter goes to CHECK.
  - CHECK (1 cycle):
    - Match requires count==CODE_LEN and buffer==stored code.
    - Match: tries_left reloads to MAX_TRIES, then OPEN.
    - Mismatch: tries_left decrements; goes to LOCKOUT if the new value is 0, else ERROR.
    - count is cleared on leaving CHECK.
  - OPEN: lasts OPEN_CYCLES cycles, or ends on the cycle after relock=1, whichever is first; then IDLE.
  - ERROR: lasts ERR_CYCLES cycles, then IDLE.
  - LOCKOUT: lasts LOCK_CYCLES cycles, then IDLE with tries_left=MAX_TRIES.
- Latency: enter sampled in cycle N; CHECK in N+1; LED asserted in N+2. All outputs are registered and decoded from state.
- Simultaneous strobes:
  - enter has priority over key_valid in the same cycle; that digit is discarded.
  - clear has priority over both.
- enter in IDLE, i.e. an empty entry, goes to CHECK and counts as a mismatch.
- key_valid, enter and clear are ignored while busy=1.
- relock outside OPEN has no effect.
- A single down-counter is shared by OPEN, ERROR and LOCKOUT.
  - Loaded with duration-1 on entering the state.
  - The state exits on the cycle the counter reads 0; no wrap-around.
- rst asserted in any state, including mid-lockout, returns to reset values on the next edge.
  - The stored code also reverts to DEFAULT_CODE.

Optional Feature:
- Macro: SAFE_LOCK_CODE_CHANGE_EN.
- Defined:
  - Adds input set_code (1 bit).
  - set_code pulsed in OPEN moves to state PROG with busy=0, led_green=1, and the open counter frozen.
  - In PROG, digits are collected as in ENTRY. enter with count==CODE_LEN writes the buffer to the stored code, then IDLE. enter with any other count leaves the code unchanged, then ERROR. clear aborts to IDLE.
  - PROG has no timeout.
- Undefined: no set_code port, no PROG state; the stored code is the constant DEFAULT_CODE.

Decomposition:
- Package safe_lock_pkg:
  - state enum: IDLE, ENTRY, CHECK, OPEN, ERROR, LOCKOUT, PROG.
  - Width helper constants: CODE_W = KEY_W*CODE_LEN and the counter width.
  - Localparam for the timer width: $clog2 of max(LOCK_CYCLES, OPEN_CYCLES, ERR_CYCLES)+1.
- Sub-module safe_lock_timer: loadable down-counter with load, value and zero flag outputs, instantiated once.

Test Plan:
- Reset, then keys 0,5,0,5 and enter (defaults) -> led_green=1 two cycles after enter, held 8 cycles; tries_left=3.
- Keys 1,2,3,4 and enter -> led_red=1 for 2 cycles; tries_left=2. Repeat twice more -> led_lock=1 for exactly 10 cycles, then tries_left=3. Keys pressed during lockout are ignored.
- Keys 0,5,0 then enter -> mismatch, short entry. Keys 0,5,0,5,7 then enter -> match, 5th digit dropped. clear after 0,5 then 0,5,0,5 and enter -> match.
- Successful open, relock at open cycle 3 -> led_green=0 on the next cycle. key_valid and enter in the same cycle -> digit discarded.
- rst pulsed in lockout cycle 5 -> led_lock=0 and tries_left=3 next cycle. With SAFE_LOCK_CODE_CHANGE_EN: open, set_code, 9,9,9,9 and enter, then 9,9,9,9 and enter -> opens; 0,5,0,5 and enter -> error.
